hash_stream_bridge: RTL

HASH_STREAM_BRIDGE -- requirements
Module: hash_stream_bridge

---
 rtl/hash_bridge_pkg.sv | 18 +
 rtl/hash_byte_packer.sv | 35 +++
 rtl/hash_stream_bridge.sv | 117 +++++++++++
 3 files changed

// File: rtl/hash_bridge_pkg.sv
// Shared types and sizes for the hash stream bridge: FSM state encoding and message geometry.
package hash_bridge_pkg;

    localparam int BYTE_W    = 8;
    localparam int MSG_BYTES = 16;
    localparam int MSG_W     = MSG_BYTES * BYTE_W;
    localparam int CNT_W     = $clog2(MSG_BYTES);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MSG_BYTES - 1);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_SEND  = 2'd3
    } state_t;

endpackage

// File: rtl/hash_byte_packer.sv
// Assembles MSG_BYTES bytes into one word, first accepted byte landing in the most significant lane.
module hash_byte_packer
    import hash_bridge_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic [BYTE_W-1:0] i_byte,
    output logic [MSG_W-1:0]  o_msg,
    output logic [CNT_W-1:0]  o_cnt
);

    logic [BYTE_W-1:0] r_bytes [MSG_BYTES];
    logic [CNT_W-1:0]  r_cnt;

    // Counter wraps naturally after the last byte, which is exactly the LOAD exit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < MSG_BYTES; k++) begin
                r_bytes[k] <= '0;
            end
            r_cnt <= '0;
        end else if (i_en) begin
            r_bytes[r_cnt] <= i_byte;
            r_cnt          <= r_cnt + 1'b1;
        end
    end

    for (genvar g = 0; g < MSG_BYTES; g++) begin : g_lane
        assign o_msg[MSG_W-1-g*BYTE_W -: BYTE_W] = r_bytes[g];
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/hash_stream_bridge.sv
// Byte-stream front end for a 128-bit hash core: packs 16 bytes, pulses start, streams the digest out.
// Optional WAIT timeout with sticky err is enabled by defining HASH_BRIDGE_TIMEOUT_EN.
module hash_stream_bridge
    import hash_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [MSG_W-1:0]  msg,
    output logic              start,
    input  logic              core_done,
    input  logic [MSG_W-1:0]  core_digest,
    output logic [BYTE_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              err
);

    state_t             r_state;
    logic [MSG_W-1:0]   r_digest;
    logic [CNT_W-1:0]   r_out_cnt;
    logic               r_done_q;
    logic [CNT_W-1:0]   w_in_cnt;
    logic               w_in_xfer;
    logic               w_out_xfer;
    logic               w_done_rise;
    logic               w_timeout;

    assign in_ready    = (r_state == ST_LOAD);
    assign start       = (r_state == ST_START);
    assign out_valid   = (r_state == ST_SEND);
    assign busy        = (r_state != ST_LOAD);
    assign out_data    = r_digest[MSG_W-1 -: BYTE_W];
    assign w_in_xfer   = in_valid & in_ready;
    assign w_out_xfer  = out_valid & out_ready;
    // A level that is already high when WAIT is entered never looks like an edge.
    assign w_done_rise = core_done & ~r_done_q;

    hash_byte_packer u_packer (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_in_xfer),
        .i_byte (in_data),
        .o_msg  (msg),
        .o_cnt  (w_in_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_LOAD;
            r_digest  <= '0;
            r_out_cnt <= '0;
            r_done_q  <= 1'b0;
        end else begin
            r_done_q <= core_done;
            case (r_state)
                ST_LOAD: begin
                    if (w_in_xfer && (w_in_cnt == LAST_IDX)) r_state <= ST_START;
                end
                ST_START: r_state <= ST_WAIT;
                ST_WAIT: begin
                    if (w_done_rise) begin
                        r_digest <= core_digest;
                        r_state  <= ST_SEND;
                    end else if (w_timeout) begin
                        r_state <= ST_LOAD;
                    end
                end
                ST_SEND: begin
                    // The outgoing byte always sits in the top lane; shift to expose the next.
                    if (w_out_xfer) begin
                        r_digest  <= {r_digest[MSG_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
                        r_out_cnt <= r_out_cnt + 1'b1;
                        if (r_out_cnt == LAST_IDX) r_state <= ST_LOAD;
                    end
                end
                default: r_state <= ST_LOAD;
            endcase
        end
    end

`ifdef HASH_BRIDGE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] r_wait_cnt;
    logic          r_err;

    assign w_timeout = (r_state == ST_WAIT) && (r_wait_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign err       = r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            r_wait_cnt <= (r_state == ST_WAIT) ? r_wait_cnt + 1'b1 : '0;
            if (w_timeout && !w_done_rise) begin
                r_err <= 1'b1;
            end else if (w_in_xfer && (w_in_cnt == '0)) begin
                r_err <= 1'b0;
            end
        end
    end
`else
    logic w_unused_timeout;

    assign w_timeout        = 1'b0;
    assign err              = 1'b0;
    assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

endmodule
